udm_rx_ctrl: RTL and testbench
==============================

Name: udm_rx_ctrl

Overview:
- Frame-level receive controller that sequences the byte stream from the UDM UART receiver.
- Parses sync, command, address and length fields, and issues one command strobe per frame.
- Buffers write-payload bytes in a small FIFO toward the bus master.
- Enforces an inter-byte timeout derived from the receiver's measured bit period, and reports protocol errors as sticky flags.

Parameters:
- FIFO_DEPTH, 4: payload FIFO entries; power of 2, minimum 2.
- TIMEOUT_BITS, 32: idle bit periods allowed between bytes inside a frame before abort; range 1..255.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- rx_done_tick_i  in  1  one-cycle byte strobe from the UART receiver.
- rx_data_bi  in  8  received byte; valid with rx_done_tick_i.
- rx_locked_i  in  1  receiver baud lock.
- bitperiod_bi  in  29  receiver bit period, in clocks.
- cmd_valid_o  out  1  one-cycle command strobe.
- cmd_bo  out  8  command code.
- addr_bo  out  32  address, little-endian assembled.
- len_bo  out  32  length in bytes, little-endian assembled.
- wdata_valid_o  out  1  FIFO not empty.
- wdata_bo  out  8  FIFO head byte.
- wdata_ready_i  in  1  consumer pops head when high together with wdata_valid_o.
- busy_o  out  1  state != IDLE.
- err_clr_i  in  1  clears all sticky errors.
- err_cmd_o  out  1  sticky: unknown command.
- err_timeout_o  out  1  sticky: inter-byte timeout.
- err_ovf_o  out  1  sticky: payload byte dropped, FIFO full.

Behaviour:
- Reset: state IDLE; all outputs 0; counters cleared; FIFO empty. Asserting reset mid-frame aborts the frame and discards FIFO contents.
- Byte ticks are ignored in every state while rx_locked_i = 0. If lock drops outside IDLE, return to IDLE with no error.
- IDLE: a tick with 0x55 goes to CMD; any other byte is discarded silently.
- CMD: on tick, latch cmd_bo.
  - 0x80 RESET: pulse cmd_valid_o next cycle, go to IDLE.
  - 0x81 WR and 0x82 RD: go to ADDR with byte counter = 0.
  - Any other code: set err_cmd_o, go to IDLE, no strobe.
- ADDR: 4 ticks, byte k written into addr_bo[8k+7:8k], then go to LEN.
- LEN: 4 ticks into len_bo in the same byte order. On the 4th tick, pulse cmd_valid_o in the following cycle.
  - RD, or WR with len = 0: go to IDLE.
  - WR with len != 0: go to DATA, remaining counter = len.
- DATA: each tick pushes rx_data_bi into the FIFO and decrements the remaining counter. At 0 go to IDLE. The full 32-bit count is honoured; no wrap.
- cmd_bo, addr_bo and len_bo hold their values until overwritten by the next frame. cmd_valid_o latency is 1 clock after the completing tick.
- FIFO:
  - A push when full, with no pop that cycle, drops the byte, sets err_ovf_o, and the counter still decrements.
  - Push and pop in the same cycle while full is accepted.
  - The pop takes effect on the clock edge where wdata_valid_o & wdata_ready_i.
  - wdata_bo is the registered head and is valid whenever wdata_valid_o = 1.
- Timeout, active in CMD, ADDR, LEN and DATA:
  - A clock counter runs to bitperiod_bi, then increments a bit counter and restarts.
  - Both counters clear on every accepted tick and on entry to a non-IDLE state.
  - When the bit counter reaches TIMEOUT_BITS: set err_timeout_o, go to IDLE, no strobe. Bytes already in the FIFO remain.
  - A tick arriving in the same cycle as a timeout wins: the byte is processed and there is no error.
- Sticky errors:
  - err_clr_i clears all sticky flags.
  - If a set event coincides with err_clr_i, the set wins.
- busy_o is combinational from state.

Decomposition:
- Package udm_pkg: state encoding (IDLE, CMD, ADDR, LEN, DATA), command codes (UDM_SYNC 0x55, UDM_CMD_RESET 0x80, UDM_CMD_WR 0x81, UDM_CMD_RD 0x82), and the field byte count 4.
- Sub-module udm_sync_fifo: parameterised depth/width, registered head, full/empty flags. The FSM, timeout counters and field assembly stay in the top.

Test Plan:
- Locked, bytes 55 82 10 32 54 76 04 00 00 00 -> one cmd_valid_o pulse, cmd_bo=0x82, addr_bo=0x76543210, len_bo=4, no FIFO activity, busy_o low after the pulse.
- Bytes 55 81 00 00 00 80 03 00 00 00 AA BB CC with wdata_ready_i=1 -> strobe after the len field with addr 0x80000000 and len 3; FIFO outputs AA, BB, CC in order; no errors.
- WR with len 6 and wdata_ready_i held 0, FIFO_DEPTH 4 -> 4 bytes stored, err_ovf_o set on byte 5, state IDLE after byte 6; FIFO drains the first 4 once ready is raised.
- bitperiod_bi=10, TIMEOUT_BITS=32, frame stops after 2 address bytes -> err_timeout_o set exactly 320 clocks after the last tick (±1 for the entry cycle), no strobe, next 55 80 yields a RESET strobe.
- Bytes 55 7F -> err_cmd_o set, no strobe; err_clr_i pulse clears it; a new err event coinciding with err_clr_i leaves the flag set.
- rst_n_i asserted mid-DATA and rx_locked_i dropped mid-ADDR -> all outputs 0 and FIFO empty immediately (async); lock drop returns to IDLE with no error flags.

Source files
------------

// File: rtl/udm_pkg.sv
// rtl/udm_pkg.sv - shared state encoding and protocol constants for the UDM receive path
package udm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_LEN  = 3'd3,
        ST_DATA = 3'd4
    } udm_state_e;

    localparam logic [7:0] UDM_SYNC      = 8'h55;
    localparam logic [7:0] UDM_CMD_RESET = 8'h80;
    localparam logic [7:0] UDM_CMD_WR    = 8'h81;
    localparam logic [7:0] UDM_CMD_RD    = 8'h82;

    localparam int UDM_FIELD_BYTES = 4;

endpackage

// File: rtl/udm_sync_fifo.sv
// rtl/udm_sync_fifo.sv - single-clock payload FIFO with head exposed from storage
module udm_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_pop;
    logic             do_push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/udm_rx_ctrl.sv
// rtl/udm_rx_ctrl.sv - UDM frame parser: sync/cmd/addr/len fields, payload FIFO, inter-byte timeout
module udm_rx_ctrl
    import udm_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        rx_done_tick_i,
    input  logic [7:0]  rx_data_bi,
    input  logic        rx_locked_i,
    input  logic [28:0] bitperiod_bi,
    output logic        cmd_valid_o,
    output logic [7:0]  cmd_bo,
    output logic [31:0] addr_bo,
    output logic [31:0] len_bo,
    output logic        wdata_valid_o,
    output logic [7:0]  wdata_bo,
    input  logic        wdata_ready_i,
    output logic        busy_o,
    input  logic        err_clr_i,
    output logic        err_cmd_o,
    output logic        err_timeout_o,
    output logic        err_ovf_o
);

    udm_state_e  state_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] remain_q;
    logic [28:0] clk_cnt_q;
    logic [7:0]  bit_cnt_q;
    logic        cmd_valid_q;
    logic [7:0]  cmd_q;
    logic [31:0] addr_q;
    logic [31:0] len_q;
    logic        err_cmd_q;
    logic        err_timeout_q;
    logic        err_ovf_q;

    logic        tick;
    logic        clk_wrap;
    logic        timeout_hit;
    logic [31:0] len_full_d;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic        cmd_bad;
    logic        last_field_byte;

    assign tick            = rx_done_tick_i && rx_locked_i;
    assign busy_o          = (state_q != ST_IDLE);
    assign last_field_byte = (byte_cnt_q == 2'(UDM_FIELD_BYTES - 1));
    assign len_full_d      = {rx_data_bi, len_q[23:0]};
    assign clk_wrap        = ({1'b0, clk_cnt_q} + 30'd1) >= {1'b0, bitperiod_bi};
    // Fires on the clock where the bit counter would step onto TIMEOUT_BITS.
    assign timeout_hit     = busy_o && clk_wrap && (bit_cnt_q == 8'(TIMEOUT_BITS - 1));
    assign cmd_bad         = tick && (state_q == ST_CMD) && (rx_data_bi != UDM_CMD_RESET) &&
                             (rx_data_bi != UDM_CMD_WR) && (rx_data_bi != UDM_CMD_RD);
    assign fifo_push       = tick && (state_q == ST_DATA);
    assign fifo_pop        = wdata_valid_o && wdata_ready_i;
    assign wdata_valid_o   = !fifo_empty;

    assign cmd_valid_o   = cmd_valid_q;
    assign cmd_bo        = cmd_q;
    assign addr_bo       = addr_q;
    assign len_bo        = len_q;
    assign err_cmd_o     = err_cmd_q;
    assign err_timeout_o = err_timeout_q;
    assign err_ovf_o     = err_ovf_q;

    udm_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push),
        .data_i  (rx_data_bi),
        .pop_i   (fifo_pop),
        .data_o  (wdata_bo),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else if (!busy_o || tick) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else if (clk_wrap) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= bit_cnt_q + 8'd1;
        end else begin
            clk_cnt_q <= clk_cnt_q + 29'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cmd_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            err_cmd_q     <= (err_cmd_q && !err_clr_i) || cmd_bad;
            err_timeout_q <= (err_timeout_q && !err_clr_i) ||
                             (timeout_hit && rx_locked_i && !tick);
            err_ovf_q     <= (err_ovf_q && !err_clr_i) || (fifo_push && fifo_full && !fifo_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            remain_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            if (!rx_locked_i) begin
                state_q <= ST_IDLE;
            end else if (tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data_bi == UDM_SYNC) state_q <= ST_CMD;
                    end
                    ST_CMD: begin
                        cmd_q      <= rx_data_bi;
                        byte_cnt_q <= '0;
                        if (rx_data_bi == UDM_CMD_RESET) begin
                            cmd_valid_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else if (rx_data_bi == UDM_CMD_WR || rx_data_bi == UDM_CMD_RD) begin
                            state_q <= ST_ADDR;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_ADDR: begin
                        addr_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data_bi;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (last_field_byte) state_q <= ST_LEN;
                    end
                    ST_LEN: begin
                        len_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data_bi;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (last_field_byte) begin
                            cmd_valid_q <= 1'b1;
                            remain_q    <= len_full_d;
                            if (cmd_q == UDM_CMD_WR && len_full_d != 32'd0) state_q <= ST_DATA;
                            else                                           state_q <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        remain_q <= remain_q - 32'd1;
                        if (remain_q == 32'd1) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (timeout_hit) begin
                state_q <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_udm_rx_ctrl.sv
// tb/tb_udm_rx_ctrl.sv - table-driven frame vectors plus directed corner sequences for udm_rx_ctrl
module tb_udm_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_tick = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_locked = 1'b1;
    logic [28:0] bitperiod = 29'd1000;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] len;
    logic        wvalid;
    logic [7:0]  wdata;
    logic        wready = 1'b0;
    logic        busy;
    logic        err_clr = 1'b0;
    logic        err_cmd;
    logic        err_to;
    logic        err_ovf;

    int checks = 0;
    int failures = 0;
    int strobes = 0;
    logic [7:0] popq[$];

    udm_rx_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_BITS(32)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .rx_done_tick_i (rx_tick),
        .rx_data_bi     (rx_data),
        .rx_locked_i    (rx_locked),
        .bitperiod_bi   (bitperiod),
        .cmd_valid_o    (cmd_valid),
        .cmd_bo         (cmd),
        .addr_bo        (addr),
        .len_bo         (len),
        .wdata_valid_o  (wvalid),
        .wdata_bo       (wdata),
        .wdata_ready_i  (wready),
        .busy_o         (busy),
        .err_clr_i      (err_clr),
        .err_cmd_o      (err_cmd),
        .err_timeout_o  (err_to),
        .err_ovf_o      (err_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid) strobes++;
        if (wvalid && wready) popq.push_back(wdata);
    end

    typedef struct {
        logic [111:0] bytes;
        int           n;
        logic         ready;
        int           exp_strobes;
        logic [7:0]   exp_cmd;
        logic [31:0]  exp_addr;
        logic [31:0]  exp_len;
        int           exp_pn;
        logic [31:0]  exp_pay;
        logic         exp_err_cmd;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data = b;
        rx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] exp_b;

        vecs[0] = '{bytes: 112'h55_82_10_32_54_76_04_00_00_00, n: 10, ready: 1'b1, exp_strobes: 1,
                    exp_cmd: 8'h82, exp_addr: 32'h76543210, exp_len: 32'd4,
                    exp_pn: 0, exp_pay: 32'h0, exp_err_cmd: 1'b0};
        vecs[1] = '{bytes: 112'h55_81_00_00_00_80_03_00_00_00_AA_BB_CC, n: 13, ready: 1'b1, exp_strobes: 1,
                    exp_cmd: 8'h81, exp_addr: 32'h80000000, exp_len: 32'd3,
                    exp_pn: 3, exp_pay: 32'h00AABBCC, exp_err_cmd: 1'b0};
        vecs[2] = '{bytes: 112'h55_80, n: 2, ready: 1'b1, exp_strobes: 1,
                    exp_cmd: 8'h80, exp_addr: 32'h80000000, exp_len: 32'd3,
                    exp_pn: 0, exp_pay: 32'h0, exp_err_cmd: 1'b0};
        vecs[3] = '{bytes: 112'h12_34_55_82_01_00_00_00_00_00_00_00, n: 12, ready: 1'b1, exp_strobes: 1,
                    exp_cmd: 8'h82, exp_addr: 32'h00000001, exp_len: 32'd0,
                    exp_pn: 0, exp_pay: 32'h0, exp_err_cmd: 1'b0};
        vecs[4] = '{bytes: 112'h55_81_FF_EE_DD_CC_00_00_00_00, n: 10, ready: 1'b1, exp_strobes: 1,
                    exp_cmd: 8'h81, exp_addr: 32'hCCDDEEFF, exp_len: 32'd0,
                    exp_pn: 0, exp_pay: 32'h0, exp_err_cmd: 1'b0};
        vecs[5] = '{bytes: 112'h55_7F, n: 2, ready: 1'b1, exp_strobes: 0,
                    exp_cmd: 8'h7F, exp_addr: 32'hCCDDEEFF, exp_len: 32'd0,
                    exp_pn: 0, exp_pay: 32'h0, exp_err_cmd: 1'b1};
        vecs[6] = '{bytes: 112'h55_81_04_00_00_00_02_00_00_00_55_81, n: 12, ready: 1'b1, exp_strobes: 1,
                    exp_cmd: 8'h81, exp_addr: 32'h00000004, exp_len: 32'd2,
                    exp_pn: 2, exp_pay: 32'h00005581, exp_err_cmd: 1'b0};

        // Reset state
        #3;
        check("rst cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst outputs", {cmd, addr, len, wdata}, 80'h0);
        check("rst flags", {wvalid, busy, err_cmd, err_to, err_ovf}, 5'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            wready = vecs[v].ready;
            strobes = 0;
            popq.delete();
            for (int k = 0; k < vecs[v].n; k++) begin
                send_byte(vecs[v].bytes[8*(vecs[v].n-1-k) +: 8], 2);
            end
            repeat (4) @(negedge clk);
            check($sformatf("v%0d strobes", v), 64'(strobes), 64'(vecs[v].exp_strobes));
            check($sformatf("v%0d cmd", v), 64'(cmd), 64'(vecs[v].exp_cmd));
            check($sformatf("v%0d addr", v), 64'(addr), 64'(vecs[v].exp_addr));
            check($sformatf("v%0d len", v), 64'(len), 64'(vecs[v].exp_len));
            check($sformatf("v%0d pops", v), 64'(popq.size()), 64'(vecs[v].exp_pn));
            for (int k = 0; k < vecs[v].exp_pn && k < popq.size(); k++) begin
                exp_b = vecs[v].exp_pay[8*(vecs[v].exp_pn-1-k) +: 8];
                check($sformatf("v%0d pay%0d", v, k), 64'(popq[k]), 64'(exp_b));
            end
            check($sformatf("v%0d errs", v), {err_cmd, err_to, err_ovf}, {vecs[v].exp_err_cmd, 2'b00});
            check($sformatf("v%0d busy", v), 64'(busy), 64'd0);
            clear_errs();
        end
        check("errs cleared", {err_cmd, err_to, err_ovf}, 3'b000);

        // Overflow: len 6 with consumer stalled
        wready = 1'b0;
        popq.delete();
        send_byte(8'h55, 1); send_byte(8'h81, 1);
        for (int k = 0; k < 4; k++) send_byte(8'h00, 1);
        send_byte(8'h06, 1);
        for (int k = 0; k < 3; k++) send_byte(8'h00, 1);
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 1);
        check("ovf before byte5", 64'(err_ovf), 64'd0);
        check("ovf busy in data", 64'(busy), 64'd1);
        send_byte(8'h05, 1);
        check("ovf after byte5", 64'(err_ovf), 64'd1);
        send_byte(8'h06, 1);
        check("ovf idle after byte6", 64'(busy), 64'd0);
        check("ovf head", 64'(wdata), 64'h01);
        @(negedge clk);
        wready = 1'b1;
        repeat (8) @(negedge clk);
        check("ovf drained", 64'(popq.size()), 64'd4);
        for (int k = 0; k < 4 && k < popq.size(); k++) begin
            check($sformatf("ovf pop%0d", k), 64'(popq[k]), 64'(k + 1));
        end
        check("ovf fifo empty", 64'(wvalid), 64'd0);
        clear_errs();

        // Timeout after two address bytes
        bitperiod = 29'd10;
        strobes = 0;
        send_byte(8'h55, 1); send_byte(8'h81, 1); send_byte(8'h11, 1);
        send_byte(8'h22, 0);
        n = 0;
        while (!err_to && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 319 || n > 321) begin
            failures++;
            $display("FAIL timeout latency: got %0d clocks expected 320", n);
        end
        check("timeout busy", 64'(busy), 64'd0);
        check("timeout no strobe", 64'(strobes), 64'd0);
        send_byte(8'h55, 1); send_byte(8'h80, 3);
        check("post-timeout reset strobe", 64'(strobes), 64'd1);
        check("post-timeout cmd", 64'(cmd), 64'h80);
        clear_errs();
        check("timeout cleared", 64'(err_to), 64'd0);
        bitperiod = 29'd1000;

        // Unknown command, clear, and set coinciding with clear
        send_byte(8'h55, 1); send_byte(8'h7F, 2);
        check("errcmd set", 64'(err_cmd), 64'd1);
        clear_errs();
        check("errcmd cleared", 64'(err_cmd), 64'd0);
        send_byte(8'h55, 1);
        @(negedge clk);
        rx_data = 8'h7F; rx_tick = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        check("errcmd set wins over clr", 64'(err_cmd), 64'd1);
        clear_errs();

        // Lock drop mid-ADDR, ticks ignored while unlocked
        send_byte(8'h55, 1); send_byte(8'h81, 1); send_byte(8'h01, 1);
        check("lock busy before drop", 64'(busy), 64'd1);
        rx_locked = 1'b0;
        send_byte(8'h55, 2);
        check("lock drop idle", 64'(busy), 64'd0);
        check("lock drop no errs", {err_cmd, err_to, err_ovf}, 3'b000);
        rx_locked = 1'b1;
        @(negedge clk);

        // Async reset mid-DATA
        wready = 1'b0;
        send_byte(8'h55, 1); send_byte(8'h81, 1);
        for (int k = 0; k < 4; k++) send_byte(8'h09, 1);
        send_byte(8'h03, 1);
        for (int k = 0; k < 3; k++) send_byte(8'h00, 1);
        send_byte(8'hA1, 1); send_byte(8'hA2, 1);
        check("pre-reset wvalid", 64'(wvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst outputs", {cmd, addr, len, wdata}, 80'h0);
        check("async rst flags", {cmd_valid, wvalid, busy, err_cmd, err_to, err_ovf}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wready = 1'b1;
        repeat (3) @(negedge clk);
        check("post-reset fifo empty", 64'(wvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
